taxi_axis_rx_frame_fifo: RTL and testbench

- Store-and-forward frame FIFO between the 10G MAC RX datapath (source) and downstream packet consumers (sink), both on taxi_axis_if.
- A frame is released to m_axis only after its tlast beat is accepted.
- Bad frames and frames that overflow the FIFO are discarded. The MAC side is never backpressured.

---
 rtl/taxi_axis_rx_frame_fifo_if.sv | 22 ++
 rtl/taxi_axis_rx_frame_fifo.sv | 158 +++++++++++++++
 tb/tb_taxi_axis_rx_frame_fifo.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/taxi_axis_rx_frame_fifo_if.sv
// AXI-Stream interface bundle shared by the MAC RX datapath and its frame consumers.
interface taxi_axis_if #(
  parameter int DATA_W  = 64,
  parameter int KEEP_W  = (DATA_W + 7) / 8,
  parameter bit ID_EN   = 1'b0,
  parameter int ID_W    = 8,
  parameter bit DEST_EN = 1'b0,
  parameter int DEST_W  = 8,
  parameter int USER_W  = 1
) ();
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [ID_W-1:0]   tid;
  logic [DEST_W-1:0] tdest;
  logic [USER_W-1:0] tuser;

  modport src (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
  modport snk (input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/taxi_axis_rx_frame_fifo.sv
// Store-and-forward RX frame FIFO: frames are released only once complete; bad or oversized frames vanish.
// Define TAXI_RX_FIFO_FRAME_LEN_EN to add committed-frame length reporting.
module taxi_axis_rx_frame_fifo #(
  parameter int DEPTH          = 64,
  parameter bit DROP_BAD_FRAME = 1'b1,
  parameter bit DROP_OVERSIZE  = 1'b1,
  localparam int ADDR_W        = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  taxi_axis_if.snk        s_axis,
  taxi_axis_if.src        m_axis,
  output logic [ADDR_W:0] status_depth,
  output logic            status_good_frame,
  output logic            status_bad_frame,
  output logic            status_overflow
`ifdef TAXI_RX_FIFO_FRAME_LEN_EN
  ,
  output logic [ADDR_W:0] status_frame_len,
  output logic            status_frame_len_valid
`endif
);
  localparam int DATA_W  = s_axis.DATA_W;
  localparam int KEEP_W  = s_axis.KEEP_W;
  localparam bit ID_EN   = s_axis.ID_EN;
  localparam int ID_W    = s_axis.ID_W;
  localparam bit DEST_EN = s_axis.DEST_EN;
  localparam int DEST_W  = s_axis.DEST_W;
  localparam int USER_W  = s_axis.USER_W;
  localparam logic [ADDR_W:0] DEPTH_P = DEPTH[ADDR_W:0];

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic [ID_W-1:0]   id;
    logic [DEST_W-1:0] dest;
    logic [USER_W-1:0] user;
  } beat_t;

  typedef enum logic [1:0] {WR_IDLE, WR_ACTIVE, WR_DROP} wr_state_t;

  wr_state_t       wr_state;
  logic [ADDR_W:0] wr_ptr_cur, wr_ptr_commit, rd_ptr;
  logic [ADDR_W:0] wr_ptr_commit_nxt, rd_ptr_nxt;
  beat_t           mem [DEPTH];
  beat_t           wr_beat, out_beat;
  logic            out_valid, out_valid_nxt, s_ready;
  logic            full, empty, accept, wr_en, commit, rd_en;

  assign full   = (wr_ptr_cur - rd_ptr) == DEPTH_P;
  assign empty  = (wr_ptr_commit == rd_ptr);
  assign accept = s_axis.tvalid && s_ready;
  assign wr_en  = accept && (wr_state != WR_DROP) && !full;
  assign commit = wr_en && s_axis.tlast && !(DROP_BAD_FRAME && s_axis.tuser[0]);
  assign rd_en  = !empty && (!out_valid || m_axis.tready);

  assign wr_ptr_commit_nxt = commit ? wr_ptr_cur + 1'b1 : wr_ptr_commit;
  assign rd_ptr_nxt        = rd_en ? rd_ptr + 1'b1 : rd_ptr;
  assign out_valid_nxt     = rd_en || (out_valid && !m_axis.tready);

  always_comb begin
    wr_beat.data = s_axis.tdata;
    wr_beat.keep = s_axis.tkeep;
    wr_beat.last = s_axis.tlast;
    wr_beat.id   = ID_EN ? s_axis.tid : '0;
    wr_beat.dest = DEST_EN ? s_axis.tdest : '0;
    wr_beat.user = s_axis.tuser;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_cur[ADDR_W-1:0]] <= wr_beat;
  end

  // Beats past the commit pointer stay invisible to the read side until their frame's tlast lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state          <= WR_IDLE;
      wr_ptr_cur        <= '0;
      wr_ptr_commit     <= '0;
      rd_ptr            <= '0;
      out_valid         <= 1'b0;
      out_beat          <= '0;
      s_ready           <= 1'b0;
      status_depth      <= '0;
      status_good_frame <= 1'b0;
      status_bad_frame  <= 1'b0;
      status_overflow   <= 1'b0;
    end else begin
      s_ready           <= 1'b1;
      status_good_frame <= 1'b0;
      status_bad_frame  <= 1'b0;
      status_overflow   <= 1'b0;
      if (accept) begin
        case (wr_state)
          WR_IDLE, WR_ACTIVE: begin
            if (full) begin
              wr_ptr_cur <= wr_ptr_commit;
              if (s_axis.tlast) begin
                status_overflow <= DROP_OVERSIZE;
                wr_state        <= WR_IDLE;
              end else begin
                wr_state <= WR_DROP;
              end
            end else if (s_axis.tlast) begin
              wr_state <= WR_IDLE;
              if (commit) begin
                wr_ptr_cur        <= wr_ptr_cur + 1'b1;
                status_good_frame <= 1'b1;
              end else begin
                wr_ptr_cur       <= wr_ptr_commit;
                status_bad_frame <= 1'b1;
              end
            end else begin
              wr_ptr_cur <= wr_ptr_cur + 1'b1;
              wr_state   <= WR_ACTIVE;
            end
          end
          WR_DROP: begin
            if (s_axis.tlast) begin
              status_overflow <= DROP_OVERSIZE;
              wr_state        <= WR_IDLE;
            end
          end
          default: wr_state <= WR_IDLE;
        endcase
      end
      wr_ptr_commit <= wr_ptr_commit_nxt;
      rd_ptr        <= rd_ptr_nxt;
      out_valid     <= out_valid_nxt;
      if (rd_en) out_beat <= mem[rd_ptr[ADDR_W-1:0]];
      // The beat parked in the output register still counts as stored.
      status_depth <= wr_ptr_commit_nxt - rd_ptr_nxt + {{ADDR_W{1'b0}}, out_valid_nxt};
    end
  end

`ifdef TAXI_RX_FIFO_FRAME_LEN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_frame_len       <= '0;
      status_frame_len_valid <= 1'b0;
    end else begin
      status_frame_len_valid <= commit;
      if (commit) status_frame_len <= wr_ptr_cur + 1'b1 - wr_ptr_commit;
    end
  end
`endif

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = out_valid;
  assign m_axis.tdata  = out_beat.data;
  assign m_axis.tkeep  = out_beat.keep;
  assign m_axis.tlast  = out_beat.last;
  assign m_axis.tid    = out_beat.id;
  assign m_axis.tdest  = out_beat.dest;
  assign m_axis.tuser  = out_beat.user;

endmodule

// File: tb/tb_taxi_axis_rx_frame_fifo.sv
// Directed bench for the RX frame FIFO: scoreboard of expected output beats plus status pulse counters.
module tb_taxi_axis_rx_frame_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  taxi_axis_if #(.DATA_W(64), .KEEP_W(8), .USER_W(1)) s_axis ();
  taxi_axis_if #(.DATA_W(64), .KEEP_W(8), .USER_W(1)) m_axis ();

  logic [AW:0] status_depth;
  logic        status_good_frame, status_bad_frame, status_overflow;
`ifdef TAXI_RX_FIFO_FRAME_LEN_EN
  logic [AW:0] status_frame_len;
  logic        status_frame_len_valid;
  int          n_len = 0;
`endif

  taxi_axis_rx_frame_fifo #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .s_axis            (s_axis),
    .m_axis            (m_axis),
    .status_depth      (status_depth),
    .status_good_frame (status_good_frame),
    .status_bad_frame  (status_bad_frame),
    .status_overflow   (status_overflow)
`ifdef TAXI_RX_FIFO_FRAME_LEN_EN
    ,
    .status_frame_len       (status_frame_len),
    .status_frame_len_valid (status_frame_len_valid)
`endif
  );

  int   checks = 0;
  int   errors = 0;
  int   n_good = 0, n_bad = 0, n_ovf = 0, n_out = 0;
  bit   rand_ready = 1'b0;
  exp_t exp_q [$];
  logic prev_stall = 1'b0;
  exp_t prev_beat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (status_good_frame === 1'b1) n_good++;
      if (status_bad_frame === 1'b1) n_bad++;
      if (status_overflow === 1'b1) n_ovf++;
`ifdef TAXI_RX_FIFO_FRAME_LEN_EN
      if (status_frame_len_valid === 1'b1) n_len++;
      if (status_frame_len_valid === 1'b1 || status_good_frame === 1'b1)
        check("len_valid_with_good", 64'(status_frame_len_valid), 64'(status_good_frame));
`endif
      if (prev_stall) begin
        check("stall_valid_held", 64'(m_axis.tvalid), 64'd1);
        check("stall_data_stable", m_axis.tdata, prev_beat.data);
        check("stall_keep_last_stable", 64'({m_axis.tkeep, m_axis.tlast}),
              64'({prev_beat.keep, prev_beat.last}));
      end
      if (m_axis.tvalid === 1'b1 && m_axis.tready === 1'b1) begin
        check("beat_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_data", m_axis.tdata, e.data);
          check("out_keep", 64'(m_axis.tkeep), 64'(e.keep));
          check("out_last", 64'(m_axis.tlast), 64'(e.last));
          n_out++;
        end
      end
      prev_stall = (m_axis.tvalid === 1'b1) && (m_axis.tready === 1'b0);
      prev_beat  = {m_axis.tdata, m_axis.tkeep, m_axis.tlast};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) m_axis.tready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drive_beat(input exp_t e, input bit bad);
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = e.data;
    s_axis.tkeep  = e.keep;
    s_axis.tlast  = e.last;
    s_axis.tuser  = 1'(bad && e.last);
  endtask

  task automatic send_frame(input int len, input bit bad, input bit expect_out);
    exp_t e;
    for (int i = 0; i < len; i++) begin
      e.data = {$urandom(), $urandom()};
      e.keep = (i == len - 1) ? 8'($urandom_range(1, 255)) : 8'hFF;
      e.last = (i == len - 1);
      drive_beat(e, bad);
      if (expect_out) exp_q.push_back(e);
      tick();
    end
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    s_axis.tuser  = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || m_axis.tvalid === 1'b1) && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic clear_counts();
    n_good = 0; n_bad = 0; n_ovf = 0; n_out = 0;
`ifdef TAXI_RX_FIFO_FRAME_LEN_EN
    n_len = 0;
`endif
  endtask

  initial begin
    int ng, nb, nbeats, len, n;
    bit bad;
    exp_t e;
    s_axis.tvalid = 1'b0; s_axis.tdata = '0; s_axis.tkeep = '0; s_axis.tlast = 1'b0;
    s_axis.tuser  = '0;   s_axis.tid   = '0; s_axis.tdest = '0;
    m_axis.tready = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_m_tvalid", 64'(m_axis.tvalid), 64'd0);
    check("rst_s_tready", 64'(s_axis.tready), 64'd0);
    check("rst_depth", 64'(status_depth), 64'd0);
    check("rst_status", 64'({status_good_frame, status_bad_frame, status_overflow}), 64'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("ready_after_reset", 64'(s_axis.tready), 64'd1);

    // 4-beat good frame, latency and drain
    clear_counts();
    send_frame(4, 1'b0, 1'b1);
    check("latency_n1_idle", 64'(m_axis.tvalid), 64'd0);
    tick();
    check("latency_n2_valid", 64'(m_axis.tvalid), 64'd1);
    wait_idle("t1_drain", 50);
    check("t1_beats", 64'(n_out), 64'd4);
    check("t1_good", 64'(n_good), 64'd1);
    check("t1_depth", 64'(status_depth), 64'd0);

    // bad frame dropped, following good frame intact
    clear_counts();
    send_frame(3, 1'b1, 1'b0);
    send_frame(2, 1'b0, 1'b1);
    wait_idle("t2_drain", 50);
    check("t2_bad", 64'(n_bad), 64'd1);
    check("t2_good", 64'(n_good), 64'd1);
    check("t2_beats", 64'(n_out), 64'd2);

    // exactly DEPTH stored while stalled, next frame overflows
    clear_counts();
    m_axis.tready = 1'b0;
    send_frame(16, 1'b0, 1'b1);
    tick(); tick();
    check("t3_depth_full", 64'(status_depth), 64'd16);
    send_frame(2, 1'b0, 1'b0);
    tick();
    check("t3_ovf", 64'(n_ovf), 64'd1);
    check("t3_good", 64'(n_good), 64'd1);
    check("t3_depth_hold", 64'(status_depth), 64'd16);
    m_axis.tready = 1'b1;
    wait_idle("t3_drain", 100);
    check("t3_beats", 64'(n_out), 64'd16);
    check("t3_depth_empty", 64'(status_depth), 64'd0);

    // DEPTH+1 frame into empty FIFO is dropped
    clear_counts();
    send_frame(17, 1'b0, 1'b0);
    tick();
    check("t4_ovf", 64'(n_ovf), 64'd1);
    check("t4_good", 64'(n_good), 64'd0);
    check("t4_depth", 64'(status_depth), 64'd0);
    repeat (4) tick();
    check("t4_beats", 64'(n_out), 64'd0);
    send_frame(16, 1'b0, 1'b1);
    wait_idle("t4_refill_drain", 100);
    check("t4_refill_beats", 64'(n_out), 64'd16);

    // random backpressure over 50 frames
    clear_counts();
    rand_ready = 1'b1;
    ng = 0; nb = 0; nbeats = 0;
    for (int f = 0; f < 50; f++) begin
      len = $urandom_range(1, 8);
      bad = ($urandom_range(0, 7) == 0);
      n = 0;
      while (int'(status_depth) + len > DEPTH && n < 200) begin
        tick();
        n++;
      end
      send_frame(len, bad, !bad);
      if (bad) nb++;
      else begin
        ng++;
        nbeats += len;
      end
    end
    rand_ready = 1'b0;
    m_axis.tready = 1'b1;
    wait_idle("t5_drain", 500);
    check("t5_good", 64'(n_good), 64'(ng));
    check("t5_bad", 64'(n_bad), 64'(nb));
    check("t5_ovf", 64'(n_ovf), 64'd0);
    check("t5_beats", 64'(n_out), 64'(nbeats));
    check("t5_depth", 64'(status_depth), 64'd0);

    // reset mid-input and mid-output frame
    m_axis.tready = 1'b0;
    send_frame(8, 1'b0, 1'b1);
    tick(); tick();
    m_axis.tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e.data = {$urandom(), $urandom()};
      e.keep = 8'hFF;
      e.last = 1'b0;
      drive_beat(e, 1'b0);
      tick();
    end
    rst_n = 1'b0;
    s_axis.tvalid = 1'b0;
    exp_q.delete();
    #1;
    check("t6_rst_tvalid", 64'(m_axis.tvalid), 64'd0);
    check("t6_rst_tready", 64'(s_axis.tready), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick(); tick();
    check("t6_depth_release", 64'(status_depth), 64'd0);
    clear_counts();
    send_frame(5, 1'b0, 1'b1);
    wait_idle("t6_drain", 50);
    check("t6_beats", 64'(n_out), 64'd5);
    check("t6_good", 64'(n_good), 64'd1);
`ifdef TAXI_RX_FIFO_FRAME_LEN_EN
    check("t6_frame_len", 64'(status_frame_len), 64'd5);
    check("t6_len_valid_count", 64'(n_len), 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
